// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared grid constants, cell codes and renderer states for the snake renderer
package snake_pkg;
   localparam int POS_W  = 8;
   localparam int LEN_W  = 4;
   localparam int NCELLS = 2 ** POS_W;

   localparam logic [POS_W-1:0] LAST_CELL = POS_W'(NCELLS - 1);

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      FOOD  = 2'b01,
      BODY  = 2'b10,
      HEAD  = 2'b11
   } cell_code_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_EMIT,
      S_DONE
   } rend_state_t;
endpackage

// File: rtl/snake_renderer_if.sv
// rtl/snake_renderer_if.sv - pixel stream from the renderer to the display driver
interface snake_renderer_if;
   import snake_pkg::*;

   logic              pix_valid;
   logic              pix_ready;
   logic [POS_W-1:0]  pix_addr;
   cell_code_t        pix_code;

   modport master (output pix_valid, output pix_addr, output pix_code, input pix_ready);
   modport slave  (input pix_valid, input pix_addr, input pix_code, output pix_ready);
endinterface

// File: rtl/snake_cell_match.sv
// rtl/snake_cell_match.sv - classifies one cell against the current location-table entry
module snake_cell_match
   import snake_pkg::*;
(
   input  logic [POS_W-1:0]  i_cell,
   input  logic [POS_W-1:0]  i_loc_data,
   input  logic [LEN_W-1:0]  i_idx,
   input  logic [LEN_W-1:0]  i_len,
   input  logic [POS_W-1:0]  i_food,
   input  logic              i_last,
   output logic              o_hit,
   output logic              o_done,
   output cell_code_t        o_code
);
   assign o_hit  = (i_len != '0) && (i_loc_data == i_cell);
   assign o_done = o_hit || i_last;

   // Snake segments win over food; index 0 of the table is the head.
   always_comb begin
      o_code = EMPTY;
      if (o_hit)
         o_code = (i_idx == '0) ? HEAD : BODY;
      else if (i_cell == i_food)
         o_code = FOOD;
   end
endmodule

// File: rtl/snake_renderer.sv
// rtl/snake_renderer.sv - raster-scans the 16x16 grid and streams classified cells; SNAKE_RENDER_SKIP_EMPTY_EN drops empty cells
module snake_renderer
   import snake_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [POS_W-1:0]  i_food,
   input  logic [LEN_W-1:0]  i_length,
   output logic [LEN_W-1:0]  o_loc_idx,
   input  logic [POS_W-1:0]  i_loc_data,
   output logic              o_busy,
   output logic              o_frame_done,
   snake_renderer_if.master  pix
);
   rend_state_t       r_state, w_state_nxt;
   logic [POS_W-1:0]  r_food, w_food_nxt;
   logic [LEN_W-1:0]  r_len, w_len_nxt;
   logic [POS_W-1:0]  r_cell, w_cell_nxt;
   logic [LEN_W-1:0]  r_idx, w_idx_nxt;
   logic [POS_W-1:0]  r_addr, w_addr_nxt;
   cell_code_t        r_code, w_code_nxt;

   logic              w_last;
   logic              w_hit;
   logic              w_done;
   cell_code_t        w_code;

   assign w_last = (r_len == '0) || (r_idx == r_len - LEN_W'(1));

   snake_cell_match u_match (
      .i_cell     (r_cell),
      .i_loc_data (i_loc_data),
      .i_idx      (r_idx),
      .i_len      (r_len),
      .i_food     (r_food),
      .i_last     (w_last),
      .o_hit      (w_hit),
      .o_done     (w_done),
      .o_code     (w_code)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_food  <= '0;
         r_len   <= '0;
         r_cell  <= '0;
         r_idx   <= '0;
         r_addr  <= '0;
         r_code  <= EMPTY;
      end else begin
         r_state <= w_state_nxt;
         r_food  <= w_food_nxt;
         r_len   <= w_len_nxt;
         r_cell  <= w_cell_nxt;
         r_idx   <= w_idx_nxt;
         r_addr  <= w_addr_nxt;
         r_code  <= w_code_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_food_nxt  = r_food;
      w_len_nxt   = r_len;
      w_cell_nxt  = r_cell;
      w_idx_nxt   = r_idx;
      w_addr_nxt  = r_addr;
      w_code_nxt  = r_code;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_food_nxt  = i_food;
               w_len_nxt   = i_length;
               w_cell_nxt  = '0;
               w_idx_nxt   = '0;
               w_state_nxt = S_SCAN;
            end
         end
         S_SCAN: begin
            if (w_done) begin
`ifdef SNAKE_RENDER_SKIP_EMPTY_EN
               if (w_code == EMPTY) begin
                  if (r_cell == LAST_CELL) begin
                     w_state_nxt = S_DONE;
                  end else begin
                     w_cell_nxt = r_cell + POS_W'(1);
                     w_idx_nxt  = '0;
                  end
               end else begin
                  w_addr_nxt  = r_cell;
                  w_code_nxt  = w_code;
                  w_state_nxt = S_EMIT;
               end
`else
               w_addr_nxt  = r_cell;
               w_code_nxt  = w_code;
               w_state_nxt = S_EMIT;
`endif
            end else begin
               w_idx_nxt = r_idx + LEN_W'(1);
            end
         end
         S_EMIT: begin
            if (pix.pix_ready) begin
               if (r_cell == LAST_CELL) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_cell_nxt  = r_cell + POS_W'(1);
                  w_idx_nxt   = '0;
                  w_state_nxt = S_SCAN;
               end
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign o_loc_idx     = r_idx;
   assign o_busy        = (r_state == S_SCAN) || (r_state == S_EMIT);
   assign o_frame_done  = (r_state == S_DONE);
   assign pix.pix_valid = (r_state == S_EMIT);
   assign pix.pix_addr  = r_addr;
   assign pix.pix_code  = r_code;
endmodule
